// File: rtl/mem_ctrl_queued.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_queued
// Purpose  : NoC home-node memory controller. Line-oriented READ, READ_EXCL
//            and WRITE requests are held in an in-order queue. One memory
//            operation is in flight at a time. Reads return a LINE_WORDS-beat
//            burst and writes return a single ACK beat.
// Options  : define MC_LAT_STATS_EN to accumulate per-direction memory latency
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl_queued #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64,
  parameter int LINE_WORDS = 8,
  parameter int REQ_DEPTH  = 4,
  parameter int NODE_W     = 8,
  parameter int CNT_W      = 32
) (
  input  logic                             clk,
  input  logic                             reset_n,
  // NoC request (ejection) side
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [2:0]                       req_type,
  input  logic [NODE_W-1:0]                req_source,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] req_wdata,
  // NoC response (injection) side
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [ADDR_WIDTH-1:0]            rsp_addr,
  output logic [2:0]                       rsp_type,
  output logic [NODE_W-1:0]                rsp_target,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic [$clog2(LINE_WORDS)-1:0]    rsp_beat,
  output logic                             rsp_last,
  // External memory side
  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic                             mem_write,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] mem_wdata,
  input  logic                             mem_resp_valid,
  output logic                             mem_resp_ready,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] mem_rdata,
  // Status and statistics
  output logic [$clog2(REQ_DEPTH):0]       queue_level,
  output logic [CNT_W-1:0]                 read_count,
  output logic [CNT_W-1:0]                 write_count,
  output logic [CNT_W-1:0]                 drop_count,
  output logic [CNT_W-1:0]                 read_latency_sum,
  output logic [CNT_W-1:0]                 write_latency_sum
);

  localparam int LINE_W = LINE_WORDS * DATA_WIDTH;
  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int OFFS_W = $clog2(LINE_W / 8);
  localparam int PTR_W  = $clog2(REQ_DEPTH);
  localparam int LVL_W  = PTR_W + 1;

  localparam logic [2:0] REQ_READ      = 3'b000;
  localparam logic [2:0] REQ_READ_EXCL = 3'b001;
  localparam logic [2:0] REQ_WRITE     = 3'b010;
  localparam logic [2:0] RSP_DATA      = 3'b100;
  localparam logic [2:0] RSP_DATA_EXCL = 3'b101;
  localparam logic [2:0] RSP_ACK       = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_SEND  = 2'd3
  } state_t;

  state_t state;

  // Queue storage: only the two type flags are kept, unknown types never enter
  logic [ADDR_WIDTH-1:0] q_addr  [REQ_DEPTH];
  logic                  q_write [REQ_DEPTH];
  logic                  q_excl  [REQ_DEPTH];
  logic [NODE_W-1:0]     q_src   [REQ_DEPTH];
  logic [LINE_W-1:0]     q_wdata [REQ_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic [LINE_W-1:0] line_buf;

  logic type_ok;
  logic accept;
  logic push;
  logic pop;

  assign type_ok     = (req_type == REQ_READ) || (req_type == REQ_READ_EXCL) ||
                       (req_type == REQ_WRITE);
  // A full queue refuses new work even if an entry leaves in the same cycle
  assign req_ready   = (level != LVL_W'(REQ_DEPTH));
  assign accept      = req_valid && req_ready;
  assign push        = accept && type_ok;
  assign pop         = (state == S_IDLE) && (level != '0);
  assign queue_level = level;

  // Capture accepted requests into the slot under the write pointer
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr]  <= req_addr;
      q_write[wr_ptr] <= (req_type == REQ_WRITE);
      q_excl[wr_ptr]  <= (req_type == REQ_READ_EXCL);
      q_src[wr_ptr]   <= req_source;
      q_wdata[wr_ptr] <= req_wdata;
    end
  end

  // Queue bookkeeping: write pointer, occupancy and rejected-request count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      level      <= '0;
      drop_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (accept && !type_ok) begin
        drop_count <= drop_count + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Request sequencer: pop, issue to memory, await data, stream the response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      rd_ptr         <= '0;
      mem_req_valid  <= 1'b0;
      mem_addr       <= '0;
      mem_write      <= 1'b0;
      mem_wdata      <= '0;
      mem_resp_ready <= 1'b0;
      line_buf       <= '0;
      rsp_valid      <= 1'b0;
      rsp_addr       <= '0;
      rsp_type       <= '0;
      rsp_target     <= '0;
      rsp_data       <= '0;
      rsp_beat       <= '0;
      rsp_last       <= 1'b0;
      read_count     <= '0;
      write_count    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            rd_ptr        <= rd_ptr + PTR_W'(1);
            state         <= S_ISSUE;
            mem_req_valid <= 1'b1;
            mem_addr      <= {q_addr[rd_ptr][ADDR_WIDTH-1:OFFS_W], {OFFS_W{1'b0}}};
            mem_write     <= q_write[rd_ptr];
            mem_wdata     <= q_wdata[rd_ptr];
            rsp_addr      <= q_addr[rd_ptr];
            rsp_target    <= q_src[rd_ptr];
            rsp_type      <= q_write[rd_ptr] ? RSP_ACK :
                             (q_excl[rd_ptr] ? RSP_DATA_EXCL : RSP_DATA);
          end
        end
        S_ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid  <= 1'b0;
            mem_resp_ready <= 1'b1;
            state          <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            // mem_write still holds the direction of the op in flight
            mem_resp_ready <= 1'b0;
            state          <= S_SEND;
            rsp_valid      <= 1'b1;
            rsp_beat       <= '0;
            line_buf       <= mem_rdata >> DATA_WIDTH;
            rsp_data       <= mem_write ? '0 : mem_rdata[DATA_WIDTH-1:0];
            rsp_last       <= mem_write;
          end
        end
        S_SEND: begin
          if (rsp_ready) begin
            if (rsp_last) begin
              rsp_valid <= 1'b0;
              rsp_last  <= 1'b0;
              state     <= S_IDLE;
              if (mem_write) begin
                write_count <= write_count + CNT_W'(1);
              end else begin
                read_count <= read_count + CNT_W'(1);
              end
            end else begin
              rsp_beat <= rsp_beat + BEAT_W'(1);
              rsp_data <= line_buf[DATA_WIDTH-1:0];
              line_buf <= line_buf >> DATA_WIDTH;
              rsp_last <= (rsp_beat == BEAT_W'(LINE_WORDS - 2));
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MC_LAT_STATS_EN
  logic [CNT_W-1:0] lat_cnt;

  // Count ISSUE/WAIT cycles; the response cycle itself is included in the sum
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_cnt           <= '0;
      read_latency_sum  <= '0;
      write_latency_sum <= '0;
    end else begin
      if (state == S_ISSUE || state == S_WAIT) begin
        lat_cnt <= lat_cnt + CNT_W'(1);
      end else begin
        lat_cnt <= '0;
      end
      if (state == S_WAIT && mem_resp_valid) begin
        if (mem_write) begin
          write_latency_sum <= write_latency_sum + lat_cnt + CNT_W'(1);
        end else begin
          read_latency_sum <= read_latency_sum + lat_cnt + CNT_W'(1);
        end
      end
    end
  end
`else
  assign read_latency_sum  = '0;
  assign write_latency_sum = '0;
`endif

endmodule
`default_nettype wire
